// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the convolution tap-issue controller.
//   conv_state_e : walk FSM states (idle, running, done pulse)
//   clog2        : ceiling log2, never below 1 so every counter/field has a real bit
//   out_w/out_h  : output feature-map edge for a stride-1 convolution
//   total_taps   : number of tap cycles in a full walk
package conv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } conv_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int unsigned out_w(input int unsigned img_w, input int unsigned ksize,
                                          input int unsigned pad);
        return img_w + 2 * pad - ksize + 1;
    endfunction

    function automatic int unsigned out_h(input int unsigned img_h, input int unsigned ksize,
                                          input int unsigned pad);
        return img_h + 2 * pad - ksize + 1;
    endfunction

    function automatic int unsigned total_taps(input int unsigned img_w, input int unsigned img_h,
                                               input int unsigned ksize, input int unsigned pad);
        return out_w(img_w, ksize, pad) * out_h(img_h, ksize, pad) * ksize * ksize;
    endfunction

endpackage

// File: rtl/conv_issue_ctrl_wrap_counter.sv
// wrap_counter: modulo-Limit up-counter with enable and carry-out, for chaining loop nests.
//   clk, aclr : clock, asynchronous active-high reset
//   clr       : synchronous clear to 0 (wins over en)
//   en        : advance by one this cycle
//   count     : current value, 0 .. Limit-1
//   carry     : en is high and count is at Limit-1 (wraps this cycle); drives the next counter's en
module wrap_counter
    import conv_pkg::*;
#(
    parameter int unsigned Limit = 4,
    parameter int unsigned Width = clog2(Limit)
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             clr,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             carry
);

    logic at_last;

    assign at_last = (count == Width'(Limit - 1));
    assign carry   = en && at_last;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_last ? '0 : count + Width'(1);
        end
    end

endmodule

// File: rtl/conv_issue_ctrl.sv
// conv_issue_ctrl: walks every output pixel and kernel tap of a stride-1 convolution, one tap per
// cycle, emitting a registered input-buffer read address plus a NOP flag for the NOP pipeline.
//   clk, aclr : clock, asynchronous active-high reset
//   start     : begin a walk (sampled only while idle)
//   stall     : hold the walk and emit a bubble (only honoured while running)
//   NOPOut    : tap is zero padding, a bubble, or no tap at all
//   Addr      : iy*ImgW+ix of the tap, 0 whenever NOPOut=1
//   TapIdx    : ky*KSize+kx of the last issued tap
//   LastTap   : final tap of the current output pixel
//   Busy      : walk in progress (running or done)
//   Done      : one-cycle pulse after the final tap
// Build option: define CONV_ISSUE_ZERO_PAD_EN to honour Pad with bounds checking; without it Pad
// is treated as 0 (valid-only convolution) and the bounds logic is not built.
module conv_issue_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned ImgW      = 4,
    parameter int unsigned ImgH      = 4,
    parameter int unsigned KSize     = 3,
    parameter int unsigned Pad       = 1,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                           clk,
    input  logic                           aclr,
    input  logic                           start,
    input  logic                           stall,
    output logic                           NOPOut,
    output logic [AddrWidth-1:0]           Addr,
    output logic [clog2(KSize*KSize)-1:0]  TapIdx,
    output logic                           LastTap,
    output logic                           Busy,
    output logic                           Done
);

`ifdef CONV_ISSUE_ZERO_PAD_EN
    localparam int unsigned PadEn = 1;
`else
    localparam int unsigned PadEn = 0;
`endif
    localparam int unsigned EffPad = Pad * PadEn;
    localparam int unsigned OutW   = out_w(ImgW, KSize, EffPad);
    localparam int unsigned OutH   = out_h(ImgH, KSize, EffPad);
    localparam int unsigned KW     = clog2(KSize);
    localparam int unsigned OxW    = clog2(OutW);
    localparam int unsigned OyW    = clog2(OutH);
    localparam int unsigned TapW   = clog2(KSize * KSize);
    localparam int unsigned CW     = AddrWidth + 1;

    conv_state_e state;

    logic           advance;
    logic           cnt_clr;
    logic [KW-1:0]  kx_cnt, ky_cnt;
    logic [OxW-1:0] ox_cnt;
    logic [OyW-1:0] oy_cnt;
    logic           kx_carry, ky_carry, ox_carry, oy_carry;

    assign advance = (state == StRun) && !stall;
    // Counters sit at 0 outside RUN, so a fresh start always begins at the first tuple.
    assign cnt_clr = (state != StRun);

    wrap_counter #(.Limit(KSize), .Width(KW)) u_kx (
        .clk(clk), .aclr(aclr), .clr(cnt_clr), .en(advance), .count(kx_cnt), .carry(kx_carry)
    );
    wrap_counter #(.Limit(KSize), .Width(KW)) u_ky (
        .clk(clk), .aclr(aclr), .clr(cnt_clr), .en(kx_carry), .count(ky_cnt), .carry(ky_carry)
    );
    wrap_counter #(.Limit(OutW), .Width(OxW)) u_ox (
        .clk(clk), .aclr(aclr), .clr(cnt_clr), .en(ky_carry), .count(ox_cnt), .carry(ox_carry)
    );
    wrap_counter #(.Limit(OutH), .Width(OyW)) u_oy (
        .clk(clk), .aclr(aclr), .clr(cnt_clr), .en(ox_carry), .count(oy_cnt), .carry(oy_carry)
    );

    logic [AddrWidth-1:0] row_c, col_c, addr_c;
    logic [TapW-1:0]      tap_c;
    logic                 oob_c;

`ifdef CONV_ISSUE_ZERO_PAD_EN
    logic signed [CW-1:0] iy_s, ix_s;

    always_comb begin
        iy_s  = $signed(CW'(oy_cnt)) + $signed(CW'(ky_cnt)) - $signed(CW'(EffPad));
        ix_s  = $signed(CW'(ox_cnt)) + $signed(CW'(kx_cnt)) - $signed(CW'(EffPad));
        // Sign bit catches the top/left border; signed compares catch bottom/right.
        oob_c = iy_s[CW-1] || ix_s[CW-1] ||
                (iy_s >= $signed(CW'(ImgH))) || (ix_s >= $signed(CW'(ImgW)));
        row_c = iy_s[AddrWidth-1:0];
        col_c = ix_s[AddrWidth-1:0];
    end
`else
    always_comb begin
        oob_c = 1'b0;
        row_c = AddrWidth'(oy_cnt) + AddrWidth'(ky_cnt);
        col_c = AddrWidth'(ox_cnt) + AddrWidth'(kx_cnt);
    end
`endif

    always_comb begin
        addr_c = row_c * AddrWidth'(ImgW) + col_c;
        tap_c  = TapW'(ky_cnt) * TapW'(KSize) + TapW'(kx_cnt);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state   <= StIdle;
            NOPOut  <= 1'b1;
            Addr    <= '0;
            TapIdx  <= '0;
            LastTap <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            // Default: no tap this cycle (idle, bubble or done).
            NOPOut  <= 1'b1;
            Addr    <= '0;
            LastTap <= 1'b0;
            Done    <= 1'b0;
            unique case (state)
                StIdle: begin
                    Busy <= 1'b0;
                    if (start) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    Busy <= 1'b1;
                    if (!stall) begin
                        NOPOut  <= oob_c;
                        Addr    <= oob_c ? '0 : addr_c;
                        TapIdx  <= tap_c;
                        // ky wraps exactly on the (K-1, K-1) tap of each pixel.
                        LastTap <= ky_carry;
                        if (oy_carry) begin
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    Busy  <= 1'b1;
                    Done  <= 1'b1;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
